// File: rtl/bt_stream_pkg.sv
`default_nettype none
// ============================================================================
// bt_stream_pkg - shared encodings for the bt_stream_framer block
// Rev 1.0
// ============================================================================
package bt_stream_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CR        = 8'h0D;
  localparam logic [7:0] LF        = 8'h0A;

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_WAIT_SAMPLE = 4'd1,
    S_WAIT_LINK   = 4'd2,
    S_SEND_BYTE   = 4'd3,
    S_WAIT_TX     = 4'd4,
    S_WAIT_RESP   = 4'd5,
    S_DONE        = 4'd6
  } fsm_state_t;

  typedef enum logic [1:0] {
    PH_SYNC    = 2'd0,
    PH_SEQ     = 2'd1,
    PH_PAYLOAD = 2'd2,
    PH_CSUM    = 2'd3
  } phase_t;

  // Index width that stays legal when only one item exists.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bt_frame_byte_sel.sv
`default_nettype none
// ============================================================================
// bt_frame_byte_sel - picks the byte to transmit for a given frame position
// Rev 1.0
// ============================================================================
module bt_frame_byte_sel
  import bt_stream_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int SAMPLE_WIDTH = 16,
  localparam int NBYTES      = SAMPLE_WIDTH / 8,
  localparam int CW          = idx_width(CHANNELS),
  localparam int BW          = idx_width(NBYTES)
) (
  input  logic [CHANNELS*SAMPLE_WIDTH-1:0] data,
  input  logic [CW-1:0]                    chan,
  input  logic [BW-1:0]                    byte_idx,
  input  phase_t                           phase,
  input  logic [7:0]                       seq,
  input  logic [7:0]                       csum,
  output logic [7:0]                       tx_byte
);

  logic [7:0] byte_tbl [CHANNELS][NBYTES];

  // Byte 0 of each channel is its most significant byte.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    for (genvar b = 0; b < NBYTES; b++) begin : g_byte
      assign byte_tbl[c][b] = data[c*SAMPLE_WIDTH + SAMPLE_WIDTH - 8*(b+1) +: 8];
    end
  end

  always_comb begin
    tx_byte = SYNC_BYTE;
    case (phase)
      PH_SYNC:    tx_byte = SYNC_BYTE;
      PH_SEQ:     tx_byte = seq;
      PH_PAYLOAD: tx_byte = byte_tbl[chan][byte_idx];
      PH_CSUM:    tx_byte = csum;
      default:    tx_byte = SYNC_BYTE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/bt_stream_framer.sv
`default_nettype none
// ============================================================================
// bt_stream_framer - framed multi-channel sample streamer and HC-05 AT client
// Rev 1.0
// ============================================================================
module bt_stream_framer
  import bt_stream_pkg::*;
#(
  parameter int          CHANNELS     = 4,
  parameter int          SAMPLE_WIDTH = 16,
  parameter int unsigned RESP_TIMEOUT = 20'd1000000
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             at_mode,
  input  logic                             bt_state,
  input  logic [CHANNELS-1:0]              chan_enable,
  input  logic [CHANNELS*SAMPLE_WIDTH-1:0] sample_data,
  input  logic                             sample_valid,
  output logic                             sample_ready,
  output logic                             tx_start,
  output logic [7:0]                       tx_data,
  input  logic                             tx_done,
  input  logic [7:0]                       rx_data,
  input  logic                             rx_valid,
  output logic                             bt_enable,
  output logic [7:0]                       resp_data,
  output logic                             resp_valid,
  output logic                             at_ok,
  output logic                             at_timeout,
  output logic                             frame_sent,
  output logic [7:0]                       seq_num,
  output logic [3:0]                       state
);

  localparam int NBYTES = SAMPLE_WIDTH / 8;
  localparam int CW     = idx_width(CHANNELS);
  localparam int BW     = idx_width(NBYTES);
  localparam int TW     = $clog2(RESP_TIMEOUT + 1);

  localparam logic [BW-1:0] LAST_BYTE  = BW'(NBYTES - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(RESP_TIMEOUT - 1);

  fsm_state_t cur_state, nxt_state;
  phase_t     cur_phase, nxt_phase, adv_phase;
  logic [CW-1:0] cur_chan, nxt_chan, adv_chan;
  logic [BW-1:0] cur_byte, nxt_byte, adv_byte;
  logic          adv_end;

  logic [CHANNELS*SAMPLE_WIDTH-1:0] data_lat, sel_data;
  logic [CHANNELS-1:0]              mask_lat;
  logic                             at_lat;
  logic [7:0]                       csum_acc, sel_byte;
  logic [TW-1:0]                    timer;
  logic                             cr_seen;

  logic          accept, load, frame_done, ok_hit, to_hit;
  logic [CW:0]   first_lat, next_lat, first_new;

  // Lowest enabled channel at or above 'from'; MSB flags that one was found.
  function automatic logic [CW:0] first_en(input logic [CHANNELS-1:0] m, input int from);
    logic [CW:0] r;
    r = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (c >= from && m[c]) r = {1'b1, CW'(c)};
    end
    return r;
  endfunction

  always_comb begin
    first_lat = first_en(mask_lat, 0);
    next_lat  = first_en(mask_lat, int'(cur_chan) + 1);
    first_new = first_en(chan_enable, 0);
  end

  // Position of the byte following the one just completed.
  always_comb begin
    adv_end   = 1'b0;
    adv_phase = cur_phase;
    adv_chan  = cur_chan;
    adv_byte  = '0;
    case (cur_phase)
      PH_SYNC: adv_phase = PH_SEQ;
      PH_SEQ: begin
        if (first_lat[CW]) begin
          adv_phase = PH_PAYLOAD;
          adv_chan  = first_lat[CW-1:0];
        end else begin
          adv_phase = PH_CSUM;
        end
      end
      PH_PAYLOAD: begin
        if (cur_byte != LAST_BYTE) begin
          adv_byte = cur_byte + 1'b1;
        end else if (next_lat[CW]) begin
          adv_chan = next_lat[CW-1:0];
        end else if (at_lat) begin
          adv_end = 1'b1;
        end else begin
          adv_phase = PH_CSUM;
        end
      end
      PH_CSUM: adv_end = 1'b1;
      default: adv_end = 1'b1;
    endcase
  end

  always_comb begin
    nxt_state  = cur_state;
    nxt_phase  = cur_phase;
    nxt_chan   = cur_chan;
    nxt_byte   = cur_byte;
    accept     = 1'b0;
    frame_done = 1'b0;
    ok_hit     = 1'b0;
    to_hit     = 1'b0;
    case (cur_state)
      S_IDLE: if (start) nxt_state = S_WAIT_SAMPLE;
      S_WAIT_SAMPLE: begin
        // A completed handshake is honoured even if start drops in the same cycle.
        if (sample_valid && sample_ready) begin
          accept   = 1'b1;
          nxt_chan = '0;
          nxt_byte = '0;
          if (!at_mode) begin
            nxt_state = S_WAIT_LINK;
            nxt_phase = PH_SYNC;
          end else if (first_new[CW]) begin
            nxt_state = S_SEND_BYTE;
            nxt_phase = PH_PAYLOAD;
            nxt_chan  = first_new[CW-1:0];
          end else begin
            nxt_state = S_WAIT_RESP;
          end
        end else if (!start) begin
          nxt_state = S_IDLE;
        end
      end
      S_WAIT_LINK: if (bt_state) nxt_state = S_SEND_BYTE;
      S_SEND_BYTE: nxt_state = S_WAIT_TX;
      S_WAIT_TX: begin
        if (tx_done) begin
          if (!at_lat && !bt_state) begin
            nxt_state = S_WAIT_LINK;
            nxt_phase = PH_SYNC;
            nxt_chan  = '0;
            nxt_byte  = '0;
          end else if (!adv_end) begin
            nxt_state = S_SEND_BYTE;
            nxt_phase = adv_phase;
            nxt_chan  = adv_chan;
            nxt_byte  = adv_byte;
          end else if (at_lat) begin
            nxt_state = S_WAIT_RESP;
          end else begin
            nxt_state  = S_WAIT_SAMPLE;
            frame_done = 1'b1;
          end
        end
      end
      S_WAIT_RESP: begin
        if (rx_valid && cr_seen && rx_data == LF) begin
          ok_hit    = 1'b1;
          nxt_state = S_DONE;
        end else if (timer == TIMER_LAST) begin
          to_hit    = 1'b1;
          nxt_state = S_DONE;
        end
      end
      S_DONE:  if (!start) nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
  end

  assign load     = (nxt_state == S_SEND_BYTE);
  assign sel_data = accept ? sample_data : data_lat;

  bt_frame_byte_sel #(
    .CHANNELS     (CHANNELS),
    .SAMPLE_WIDTH (SAMPLE_WIDTH)
  ) u_byte_sel (
    .data     (sel_data),
    .chan     (nxt_chan),
    .byte_idx (nxt_byte),
    .phase    (nxt_phase),
    .seq      (seq_num),
    .csum     (csum_acc),
    .tx_byte  (sel_byte)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_state <= S_IDLE;
      cur_phase <= PH_SYNC;
      cur_chan  <= '0;
      cur_byte  <= '0;
    end else begin
      cur_state <= nxt_state;
      cur_phase <= nxt_phase;
      cur_chan  <= nxt_chan;
      cur_byte  <= nxt_byte;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_lat     <= '0;
      mask_lat     <= '0;
      at_lat       <= 1'b0;
      csum_acc     <= '0;
      timer        <= '0;
      cr_seen      <= 1'b0;
      seq_num      <= '0;
      tx_data      <= '0;
      tx_start     <= 1'b0;
      sample_ready <= 1'b0;
      bt_enable    <= 1'b0;
      frame_sent   <= 1'b0;
      at_ok        <= 1'b0;
      at_timeout   <= 1'b0;
      resp_valid   <= 1'b0;
      resp_data    <= '0;
    end else begin
      if (accept) begin
        data_lat <= sample_data;
        mask_lat <= chan_enable;
        at_lat   <= at_mode;
      end
      // Checksum covers the sequence byte and payload, restarting at each sync byte.
      if (load) begin
        tx_data <= sel_byte;
        if (nxt_phase == PH_SYNC)      csum_acc <= '0;
        else if (nxt_phase != PH_CSUM) csum_acc <= csum_acc ^ sel_byte;
      end
      if (frame_done) seq_num <= seq_num + 8'd1;

      if (cur_state != S_WAIT_RESP) begin
        timer   <= '0;
        cr_seen <= 1'b0;
      end else begin
        timer <= timer + 1'b1;
        if (rx_valid) cr_seen <= (rx_data == CR);
      end

      resp_valid <= (cur_state == S_WAIT_RESP) && rx_valid;
      if ((cur_state == S_WAIT_RESP) && rx_valid) resp_data <= rx_data;

      tx_start     <= load;
      sample_ready <= (nxt_state == S_WAIT_SAMPLE);
      bt_enable    <= (nxt_state != S_IDLE) && (nxt_state != S_DONE);
      frame_sent   <= frame_done;
      at_ok        <= ok_hit;
      at_timeout   <= to_hit;
    end
  end

  assign state = cur_state;

endmodule
`default_nettype wire

// File: tb/tb_bt_stream_framer.sv
`default_nettype none
// ============================================================================
// tb_bt_stream_framer - directed self-checking bench for bt_stream_framer
// Rev 1.0
// ============================================================================
module tb_bt_stream_framer;

  localparam int CH     = 2;
  localparam int SW     = 16;
  localparam int TO     = 100;
  localparam int TX_LAT = 2;

  logic              clock = 1'b0;
  logic              reset, start, at_mode, bt_state;
  logic [CH-1:0]     chan_enable;
  logic [CH*SW-1:0]  sample_data;
  logic              sample_valid, sample_ready;
  logic              tx_start, tx_done;
  logic [7:0]        tx_data, rx_data;
  logic              rx_valid, bt_enable, resp_valid, at_ok, at_timeout, frame_sent;
  logic [7:0]        resp_data, seq_num;
  logic [3:0]        state;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         uart_cnt = 0;
  logic [7:0] uart_byte;
  logic [7:0] tx_log [$];

  typedef struct {
    logic [1:0]  mask;
    logic [31:0] data;
    int          len;
    logic [79:0] bytes;
    logic [7:0]  seq_after;
  } vec_t;

  vec_t vecs [5];

  bt_stream_framer #(
    .CHANNELS     (CH),
    .SAMPLE_WIDTH (SW),
    .RESP_TIMEOUT (TO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .at_mode      (at_mode),
    .bt_state     (bt_state),
    .chan_enable  (chan_enable),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_done      (tx_done),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .bt_enable    (bt_enable),
    .resp_data    (resp_data),
    .resp_valid   (resp_valid),
    .at_ok        (at_ok),
    .at_timeout   (at_timeout),
    .frame_sent   (frame_sent),
    .seq_num      (seq_num),
    .state        (state)
  );

  initial forever #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // UART transmitter model: logs each byte, answers with tx_done TX_LAT cycles later.
  initial begin
    tx_done = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      tx_done = 1'b0;
      if (reset) begin
        uart_cnt = 0;
      end else if (uart_cnt > 0) begin
        uart_cnt--;
        if (uart_cnt == 0) begin
          tx_done = 1'b1;
          check("tx_data_hold", tx_data, uart_byte);
        end
      end else if (tx_start) begin
        tx_log.push_back(tx_data);
        uart_byte = tx_data;
        uart_cnt  = TX_LAT;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, CHECKS %0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic offer(input logic atm, input logic [CH-1:0] m, input logic [CH*SW-1:0] d);
    int n;
    n = 0;
    while (sample_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("offer_ready", sample_ready, 1'b1);
    at_mode      = atm;
    chan_enable  = m;
    sample_data  = d;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    chan_enable  = ~m;
    sample_data  = ~d;
  endtask

  task automatic wait_state(input logic [3:0] s, input int limit, input string name);
    int n;
    n = 0;
    while (state !== s && n < limit) begin
      tick();
      n++;
    end
    check(name, state, s);
  endtask

  task automatic wait_frame(input string name);
    int n;
    n = 0;
    while (frame_sent !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check(name, frame_sent, 1'b1);
  endtask

  task automatic wait_log(input int len, input string name);
    int n;
    n = 0;
    while (tx_log.size() < len && n < 200) begin
      tick();
      n++;
    end
    check(name, tx_log.size(), len);
  endtask

  task automatic check_log(input string name, input logic [79:0] exp, input int len);
    check({name, "_len"}, tx_log.size(), len);
    for (int i = 0; i < len && i < tx_log.size(); i++)
      check($sformatf("%s_b%0d", name, i), tx_log[i], exp[79-8*i -: 8]);
  endtask

  initial begin
    logic [7:0]  s;
    logic [31:0] rsp;
    int          e_cyc, to_cyc;
    logic        to_seen, ok_seen;

    vecs[0] = '{2'b11, 32'hABCD_1234, 7, 80'hA5_00_12_34_AB_CD_40_00_00_00, 8'h01};
    vecs[1] = '{2'b10, 32'hABCD_1234, 5, 80'hA5_01_AB_CD_67_00_00_00_00_00, 8'h02};
    vecs[2] = '{2'b00, 32'h5555_AAAA, 3, 80'hA5_02_02_00_00_00_00_00_00_00, 8'h03};
    vecs[3] = '{2'b01, 32'hABCD_1234, 5, 80'hA5_03_12_34_25_00_00_00_00_00, 8'h04};
    vecs[4] = '{2'b11, 32'h00FF_8001, 7, 80'hA5_04_80_01_00_FF_7A_00_00_00, 8'h05};

    reset = 1'b1; start = 1'b0; at_mode = 1'b0; bt_state = 1'b1;
    chan_enable = '0; sample_data = '0; sample_valid = 1'b0;
    rx_data = '0; rx_valid = 1'b0;
    tick();
    tick();
    check("reset_outputs", {tx_start, tx_data, sample_ready, bt_enable, resp_valid, resp_data,
                            at_ok, at_timeout, frame_sent, seq_num, state}, 64'd0);
    reset = 1'b0;
    tick();
    check("idle_hold", state, 4'd0);
    start = 1'b1;
    tick();
    check("to_wait_sample", {state, sample_ready, bt_enable}, {4'd1, 1'b1, 1'b1});

    // Streaming frames from the vector table.
    for (int i = 0; i < 5; i++) begin
      tx_log.delete();
      offer(1'b0, vecs[i].mask, vecs[i].data);
      check($sformatf("v%0d_wait_link", i), state, 4'd2);
      tick();
      check($sformatf("v%0d_tx_start", i), tx_start, 1'b1);
      wait_frame($sformatf("v%0d_frame_sent", i));
      check($sformatf("v%0d_ready", i), sample_ready, 1'b1);
      check($sformatf("v%0d_seq", i), seq_num, vecs[i].seq_after);
      check_log($sformatf("v%0d", i), vecs[i].bytes, vecs[i].len);
      tick();
      check($sformatf("v%0d_sent_pulse", i), frame_sent, 1'b0);
    end

    // Reset in the middle of a byte.
    tx_log.delete();
    offer(1'b0, 2'b11, 32'hABCD_1234);
    wait_log(2, "rst_pre_bytes");
    #1;
    reset = 1'b1;
    #1;
    check("rst_mid_outputs", {tx_start, tx_data, sample_ready, bt_enable, resp_valid, resp_data,
                              at_ok, at_timeout, frame_sent, seq_num, state}, 64'd0);
    tick();
    reset = 1'b0;
    tx_log.delete();
    repeat (12) tick();
    check("rst_no_tx", tx_log.size(), 0);
    check("rst_state", state, 4'd1);

    // Link loss during the third byte: frame restarts with the same sequence number.
    tx_log.delete();
    bt_state = 1'b1;
    offer(1'b0, 2'b11, 32'hABCD_1234);
    wait_log(3, "drop_third_byte");
    bt_state = 1'b0;
    repeat (10) tick();
    check("drop_state", state, 4'd2);
    check("drop_len", tx_log.size(), 3);
    check("drop_seq_hold", seq_num, 8'h00);
    check("drop_no_sent", frame_sent, 1'b0);
    bt_state = 1'b1;
    wait_frame("drop_frame_sent");
    check_log("drop", 80'hA5_00_12_A5_00_12_34_AB_CD_40, 10);
    check("drop_seq", seq_num, 8'h01);

    // Empty-mask frames up to and across the sequence wrap.
    for (int i = 1; i <= 255; i++) begin
      s = 8'(i);
      tx_log.delete();
      offer(1'b0, 2'b00, 32'(i));
      wait_frame($sformatf("wrap%0d_sent", i));
      check($sformatf("wrap%0d_frame", i),
            {8'(tx_log.size()), tx_log[0], tx_log[1], tx_log[2]}, {8'd3, 8'hA5, s, s});
    end
    check("seq_wrap", seq_num, 8'h00);

    // AT command with an OK CR LF response.
    tx_log.delete();
    offer(1'b1, 2'b01, 32'hDEAD_4154);
    check("at_tx_start", tx_start, 1'b1);
    wait_state(4'd5, 100, "at_wait_resp");
    check_log("at", 80'h41_54_00_00_00_00_00_00_00_00, 2);
    check("at_bt_en", bt_enable, 1'b1);
    rsp = 32'h4F4B_0D0A;
    for (int i = 0; i < 4; i++) begin
      rx_data  = rsp[31-8*i -: 8];
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      check($sformatf("at_resp%0d", i), {resp_valid, resp_data}, {1'b1, rsp[31-8*i -: 8]});
      check($sformatf("at_ok%0d", i), at_ok, (i == 3));
      if (i < 3) begin
        tick();
        tick();
      end
    end
    check("at_done", {state, bt_enable}, {4'd6, 1'b0});
    tick();
    check("at_ok_pulse", {at_ok, resp_valid}, 2'b00);
    start = 1'b0;
    tick();
    tick();
    check("at_to_idle", state, 4'd0);

    // AT command whose response never terminates: timeout.
    start = 1'b1;
    tick();
    tx_log.delete();
    offer(1'b1, 2'b01, 32'h0000_4154);
    wait_state(4'd5, 100, "to_wait_resp");
    e_cyc   = cyc;
    to_seen = 1'b0;
    ok_seen = 1'b0;
    to_cyc  = 0;
    for (int k = 1; k <= 300 && !to_seen; k++) begin
      rx_valid = (k == 3) || (k == 7);
      rx_data  = (k == 3) ? 8'h0D : 8'h41;
      tick();
      if (at_ok) ok_seen = 1'b1;
      if (at_timeout) begin
        to_seen = 1'b1;
        to_cyc  = cyc;
      end
    end
    rx_valid = 1'b0;
    check("to_seen", to_seen, 1'b1);
    check("to_latency", to_cyc - e_cyc, TO);
    check("to_no_ok", ok_seen, 1'b0);
    check("to_done", state, 4'd6);
    tick();
    check("to_pulse", at_timeout, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
